fb_px_responder: RTL

Frame-buffer responder for the CPU's pixel interface (px_request/px_write/px_address/px_write_data → px_ready/px_read_data). Holds a single-port synchronous pixel RAM, answers CPU reads and writes with a four-phase handshake, and, when configured, time-shares the RAM with a sequential scan-out engine feeding the display path. Sits between the CPU core and the display logic at the top level, in place of a behavioural frame-buffer model.

---
 rtl/fb_px_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fb_px_responder.sv
// ---------------------------------------------------------------------------
// fb_px_responder
// Frame-buffer responder for the CPU pixel interface. A single-port
// synchronous pixel RAM answers CPU reads/writes through a four-phase
// request/ready handshake. With FB_SCANOUT_EN defined, a sequential scan-out
// engine time-shares the same RAM port and has strict priority over the CPU.
//
// Optional feature macro: FB_SCANOUT_EN (scan engine + arbitration).
//
// Ports
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high
//   px_request     in   CPU request level, held until px_ready seen
//   px_write       in   1 = write, 0 = read
//   px_address     in   16-bit pixel address (bits >= ADDR_W ignored)
//   px_write_data  in   write pixel
//   px_ready       out  completion, high until px_request drops
//   px_read_data   out  last completed read result
//   scan_en        in   scan engine enable
//   scan_pixel     out  scanned pixel
//   scan_valid     out  one-cycle strobe for scan_pixel
//   scan_sof       out  with scan_valid when the pixel came from address 0
//
// CPU FSM
//   state  | meaning
//   IDLE   | waiting for px_request
//   ACCESS | RAM op this cycle unless a scan slot owns the port
//   DONE   | op finished; px_ready raised, waiting for px_request low
// ---------------------------------------------------------------------------
module fb_px_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 24,
    parameter int PIX_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              px_request,
    input  logic              px_write,
    input  logic [15:0]       px_address,
    input  logic [DATA_W-1:0] px_write_data,
    output logic              px_ready,
    output logic [DATA_W-1:0] px_read_data,
    input  logic              scan_en,
    output logic [DATA_W-1:0] scan_pixel,
    output logic              scan_valid,
    output logic              scan_sof
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] cpu_addr;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] port_addr;
    logic              port_we;
    logic              port_re;
    logic              scan_slot;
    logic              cpu_op;

    assign cpu_addr = px_address[ADDR_W-1:0];

    always_comb begin
        state_nxt = state;
        cpu_op    = 1'b0;
        case (state)
            IDLE: begin
                if (px_request) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!px_request) begin
                    state_nxt = IDLE;
                end else if (!scan_slot) begin
                    cpu_op    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!px_request) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The read result sits in ram_q during the first DONE cycle and is
    // copied out together with px_ready, so px_read_data never changes
    // before the handshake reports completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            px_ready     <= 1'b0;
            px_read_data <= '0;
        end else begin
            px_ready <= (state == DONE) && px_request;
            if ((state == DONE) && px_request && !px_ready && !px_write)
                px_read_data <= ram_q;
        end
    end

    // Single RAM port: the scan slot and a CPU op are mutually exclusive.
    assign port_addr = scan_slot ? scan_addr : cpu_addr;
    assign port_we   = cpu_op && px_write && !reset;
    assign port_re   = scan_slot || (cpu_op && !px_write);

    always_ff @(posedge clk) begin
        if (port_we) mem[port_addr] <= px_write_data;
        if (port_re) ram_q <= mem[port_addr];
    end

`ifdef FB_SCANOUT_EN
    localparam int DIV_W = $clog2(PIX_DIV);

    logic [DIV_W-1:0]  div_cnt;
    logic              scan_valid_r;
    logic              scan_sof_r;
    logic [DATA_W-1:0] scan_hold;

    assign scan_slot = scan_en && (div_cnt == DIV_W'(PIX_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            scan_addr    <= '0;
            scan_valid_r <= 1'b0;
            scan_sof_r   <= 1'b0;
            scan_hold    <= '0;
        end else begin
            if (!scan_en || scan_slot) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;
            if (scan_slot) scan_addr <= scan_addr + 1'b1;
            scan_valid_r <= scan_slot;
            scan_sof_r   <= scan_slot && (scan_addr == '0);
            if (scan_valid_r) scan_hold <= ram_q;
        end
    end

    // ram_q carries the scanned pixel only during the strobe cycle; the
    // hold register keeps scan_pixel stable between strobes.
    assign scan_pixel = scan_valid_r ? ram_q : scan_hold;
    assign scan_valid = scan_valid_r;
    assign scan_sof   = scan_sof_r;
`else
    assign scan_slot  = 1'b0;
    assign scan_addr  = '0;
    assign scan_pixel = '0;
    assign scan_valid = 1'b0;
    assign scan_sof   = 1'b0;

    logic unused_scan;
    assign unused_scan = scan_en;
`endif

    logic unused_addr;
    assign unused_addr = ^px_address[15:ADDR_W];

endmodule
